traffic_light_monitor: RTL and testbench

Passive safety and timing checker on the lamp outputs of the traffic light controller. It samples the six lamp signals Ga/Ya/Ra/Gb/Yb/Rb every clock and tracks each street's phase. It flags illegal lamp combinations, conflicting right-of-way, illegal phase sequences and yellow/green duration violations. It sits beside the controller in the top level and in benches, and consumes the controller's output interface.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/traffic_light_monitor_if.sv | 10 +
 rtl/traffic_street_tracker.sv | 92 +++++++++
 rtl/traffic_light_monitor.sv | 88 ++++++++
 tb/tb_traffic_light_monitor.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding, fault codes and lamp decode helper
// for the traffic light controller and its monitor.
// Contents: phase_t, FLT_* fault code constants, decode_lamps().
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_UNK    = 2'd3
  } phase_t;

  localparam logic [2:0] FLT_NONE         = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL_LAMP = 3'd1;
  localparam logic [2:0] FLT_CONFLICT     = 3'd2;
  localparam logic [2:0] FLT_BAD_SEQ      = 3'd3;
  localparam logic [2:0] FLT_YELLOW_TIME  = 3'd4;
  localparam logic [2:0] FLT_SHORT_GREEN  = 3'd5;

  // A street only has a meaningful phase when exactly one lamp is lit.
  function automatic phase_t decode_lamps(input logic g, input logic y, input logic r);
    phase_t ph;
    unique case ({g, y, r})
      3'b100:  ph = PH_GREEN;
      3'b010:  ph = PH_YELLOW;
      3'b001:  ph = PH_RED;
      default: ph = PH_UNK;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: the six lamp outputs of the traffic light controller.
// Ports: Ga/Ya/Ra (street A), Gb/Yb/Rb (street B); all synchronous to the controller clock.
// Modports: master = controller (drives lamps), slave = monitor (observes lamps).
interface traffic_light_monitor_if;
  logic Ga, Ya, Ra;
  logic Gb, Yb, Rb;

  modport master (output Ga, Ya, Ra, Gb, Yb, Rb);
  modport slave  (input  Ga, Ya, Ra, Gb, Yb, Rb);
endinterface

// File: rtl/traffic_street_tracker.sv
// traffic_street_tracker: per-street phase tracker; decodes lamps, runs the phase FSM
// and duration counter, and flags violations of the current sample (combinational flags).
// Ports: clk, reset_n, g/y/r lamps in; phase (registered), sample_phase, illegal, bad_seq,
// yellow_time, short_green, green_done out.
module traffic_street_tracker
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = 5,
  parameter int MIN_GREEN     = 6,
  parameter int CNT_W         = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   g,
  input  logic   y,
  input  logic   r,
  output phase_t phase,
  output phase_t sample_phase,
  output logic   illegal,
  output logic   bad_seq,
  output logic   yellow_time,
  output logic   short_green,
  output logic   green_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] Y_CNT   = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] G_MIN   = CNT_W'(MIN_GREEN);

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set when the current phase was entered from a known phase; a phase
  // picked up from UNK has an unknown true length and is not timed.
  logic             checked_q, checked_d;
  phase_t           cur;

  assign cur          = decode_lamps(g, y, r);
  assign sample_phase = cur;
  assign phase        = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PH_UNK;
      cnt_q     <= '0;
      checked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      checked_q <= checked_d;
    end
  end

  always_comb begin
    state_d     = cur;
    cnt_d       = cnt_q;
    checked_d   = checked_q;
    illegal     = (cur == PH_UNK);
    bad_seq     = 1'b0;
    yellow_time = 1'b0;
    short_green = 1'b0;
    green_done  = 1'b0;

    if (cur == PH_UNK) begin
      cnt_d     = '0;
      checked_d = 1'b0;
    end else if (cur != state_q) begin
      cnt_d     = CNT_ONE;
      checked_d = (state_q != PH_UNK);
      unique case (state_q)
        PH_RED:    bad_seq = (cur != PH_GREEN);
        PH_GREEN: begin
          bad_seq = (cur != PH_YELLOW);
          if (cur == PH_YELLOW) begin
            green_done  = 1'b1;
            short_green = checked_q && (cnt_q < G_MIN);
          end
        end
        PH_YELLOW: begin
          bad_seq = (cur != PH_RED);
          if (cur == PH_RED) yellow_time = checked_q && (cnt_q != Y_CNT);
        end
        default: ;  // from UNK any valid phase is accepted
      endcase
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      // Fires once, on the sample that takes the count to YELLOW_CYCLES+1.
      if (cur == PH_YELLOW && checked_q && cnt_q == Y_CNT) yellow_time = 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive lamp safety/timing checker beside the controller.
// Ports: clk, reset_n, lamps (slave modport); phase_a/phase_b, fault, fault_code,
// err_count, green_cnt_a/green_cnt_b. Optional macro MONITOR_STATS_EN builds the counters.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = 5,
  parameter int MIN_GREEN     = 6,
  parameter int CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  traffic_light_monitor_if.slave        lamps,
  output phase_t                        phase_a,
  output phase_t                        phase_b,
  output logic                          fault,
  output logic [2:0]                    fault_code,
  output logic [7:0]                    err_count,
  output logic [15:0]                   green_cnt_a,
  output logic [15:0]                   green_cnt_b
);

  phase_t     samp_a, samp_b;
  logic       ill_a, seq_a, yt_a, sg_a, gd_a;
  logic       ill_b, seq_b, yt_b, sg_b, gd_b;
  logic       conflict;
  logic [2:0] code_d;
  logic       viol;

  traffic_street_tracker #(.YELLOW_CYCLES(YELLOW_CYCLES), .MIN_GREEN(MIN_GREEN), .CNT_W(CNT_W)) u_trk_a (
    .clk(clk), .reset_n(reset_n), .g(lamps.Ga), .y(lamps.Ya), .r(lamps.Ra),
    .phase(phase_a), .sample_phase(samp_a), .illegal(ill_a), .bad_seq(seq_a),
    .yellow_time(yt_a), .short_green(sg_a), .green_done(gd_a)
  );

  traffic_street_tracker #(.YELLOW_CYCLES(YELLOW_CYCLES), .MIN_GREEN(MIN_GREEN), .CNT_W(CNT_W)) u_trk_b (
    .clk(clk), .reset_n(reset_n), .g(lamps.Gb), .y(lamps.Yb), .r(lamps.Rb),
    .phase(phase_b), .sample_phase(samp_b), .illegal(ill_b), .bad_seq(seq_b),
    .yellow_time(yt_b), .short_green(sg_b), .green_done(gd_b)
  );

  // Right-of-way conflict only judged when both streets show a single lamp.
  assign conflict = !ill_a && !ill_b && (samp_a != PH_RED) && (samp_b != PH_RED);

  // Written highest code first so the lowest-numbered violation wins.
  always_comb begin
    code_d = FLT_NONE;
    if (sg_a || sg_b)   code_d = FLT_SHORT_GREEN;
    if (yt_a || yt_b)   code_d = FLT_YELLOW_TIME;
    if (seq_a || seq_b) code_d = FLT_BAD_SEQ;
    if (conflict)       code_d = FLT_CONFLICT;
    if (ill_a || ill_b) code_d = FLT_ILLEGAL_LAMP;
  end

  assign viol = (code_d != FLT_NONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else if (viol && !fault) begin
      fault      <= 1'b1;
      fault_code <= code_d;
    end
  end

`ifdef MONITOR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count   <= '0;
      green_cnt_a <= '0;
      green_cnt_b <= '0;
    end else begin
      if (viol && err_count != 8'hFF)        err_count   <= err_count + 8'd1;
      if (gd_a && green_cnt_a != 16'hFFFF)   green_cnt_a <= green_cnt_a + 16'd1;
      if (gd_b && green_cnt_b != 16'hFFFF)   green_cnt_b <= green_cnt_b + 16'd1;
    end
  end
`else
  // Green-done pulses have no consumer when statistics are not built.
  logic stats_unused;
  assign stats_unused = gd_a | gd_b;
  assign err_count    = '0;
  assign green_cnt_a  = '0;
  assign green_cnt_b  = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed self-checking bench for traffic_light_monitor.
// Drives lamp patterns through the interface, checks outputs #1 after each rising edge.
// Counter expectations scale to zero when MONITOR_STATS_EN is not defined.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

`ifdef MONITOR_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  // {Ga,Ya,Ra,Gb,Yb,Rb}
  localparam logic [5:0] RR   = 6'b001_001;
  localparam logic [5:0] GR   = 6'b100_001;
  localparam logic [5:0] YR   = 6'b010_001;
  localparam logic [5:0] RG   = 6'b001_100;
  localparam logic [5:0] RY   = 6'b001_010;
  localparam logic [5:0] GG   = 6'b100_100;
  localparam logic [5:0] BADA = 6'b110_100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  phase_t      phase_a, phase_b;
  logic        fault;
  logic [2:0]  fault_code;
  logic [7:0]  err_count;
  logic [15:0] green_cnt_a, green_cnt_b;

  int errors = 0;
  int checks = 0;

  traffic_light_monitor_if lamps ();

  traffic_light_monitor dut (
    .clk(clk), .reset_n(reset_n), .lamps(lamps.slave),
    .phase_a(phase_a), .phase_b(phase_b), .fault(fault), .fault_code(fault_code),
    .err_count(err_count), .green_cnt_a(green_cnt_a), .green_cnt_b(green_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lamps(input logic [5:0] l);
    {lamps.Ga, lamps.Ya, lamps.Ra, lamps.Gb, lamps.Yb, lamps.Rb} = l;
  endtask

  task automatic drive(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      set_lamps(l);
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse placed between edges; outputs checked before any edge.
  task automatic pulse_reset(input string tag, input logic [5:0] l_at_release);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_ph_a"}, 16'(phase_a), 16'(PH_UNK));
    chk({tag, "_ph_b"}, 16'(phase_b), 16'(PH_UNK));
    chk({tag, "_fault"}, 16'(fault), 16'd0);
    chk({tag, "_code"}, 16'(fault_code), 16'd0);
    chk({tag, "_err"}, 16'(err_count), 16'd0);
    chk({tag, "_gca"}, green_cnt_a, 16'd0);
    chk({tag, "_gcb"}, green_cnt_b, 16'd0);
    set_lamps(l_at_release);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    set_lamps(RR);
    pulse_reset("rst0", RR);

    // Legal rotation
    drive(RR, 2);
    drive(GR, 1);
    chk("rot_ph_a_green", 16'(phase_a), 16'(PH_GREEN));
    drive(GR, 7);
    drive(YR, 5);
    drive(RR, 1);
    chk("rot_ph_a_red", 16'(phase_a), 16'(PH_RED));
    drive(RG, 8);
    drive(RY, 5);
    drive(RR, 2);
    chk("rot_fault", 16'(fault), 16'd0);
    chk("rot_err", 16'(err_count), 16'd0);
    chk("rot_gca", green_cnt_a, 16'(STATS));
    chk("rot_gcb", green_cnt_b, 16'(STATS));
    chk("rot_ph_b", 16'(phase_b), 16'(PH_RED));

    // Conflict
    drive(GR, 2);
    chk("cf_pre_fault", 16'(fault), 16'd0);
    drive(GG, 1);
    chk("cf_fault", 16'(fault), 16'd1);
    chk("cf_code", 16'(fault_code), 16'(FLT_CONFLICT));
    chk("cf_err", 16'(err_count), 16'(STATS));

    // Short yellow
    pulse_reset("rst1", RR);
    drive(RR, 1);
    drive(GR, 8);
    drive(YR, 3);
    chk("sy_pre_fault", 16'(fault), 16'd0);
    drive(RR, 1);
    chk("sy_fault", 16'(fault), 16'd1);
    chk("sy_code", 16'(fault_code), 16'(FLT_YELLOW_TIME));
    chk("sy_gca", green_cnt_a, 16'(STATS));
    chk("sy_err", 16'(err_count), 16'(STATS));

    // Long yellow: flagged on the sixth yellow sample, not the fifth
    pulse_reset("rst2", RR);
    drive(RR, 1);
    drive(GR, 8);
    drive(YR, 5);
    chk("ly_y5_fault", 16'(fault), 16'd0);
    drive(YR, 1);
    chk("ly_y6_fault", 16'(fault), 16'd1);
    chk("ly_y6_code", 16'(fault_code), 16'(FLT_YELLOW_TIME));
    chk("ly_y6_err", 16'(err_count), 16'(STATS));
    drive(YR, 1);
    chk("ly_y7_err", 16'(err_count), 16'(STATS));
    drive(RR, 1);
    chk("ly_red_err", 16'(err_count), 16'(2 * STATS));
    chk("ly_red_code", 16'(fault_code), 16'(FLT_YELLOW_TIME));

    // Bad sequence GREEN->RED
    pulse_reset("rst3", RR);
    drive(RR, 1);
    drive(GR, 3);
    drive(RR, 1);
    chk("bs_fault", 16'(fault), 16'd1);
    chk("bs_code", 16'(fault_code), 16'(FLT_BAD_SEQ));
    chk("bs_err", 16'(err_count), 16'(STATS));

    // Simultaneous violations and stickiness
    pulse_reset("rst4", RR);
    drive(RR, 1);
    drive(BADA, 2);
    chk("sim_code", 16'(fault_code), 16'(FLT_ILLEGAL_LAMP));
    chk("sim_err", 16'(err_count), 16'(2 * STATS));
    chk("sim_ph_a", 16'(phase_a), 16'(PH_UNK));
    chk("sim_ph_b", 16'(phase_b), 16'(PH_GREEN));
    drive(RY, 1);  // B green lasted only 2 samples
    chk("sg_code", 16'(fault_code), 16'(FLT_ILLEGAL_LAMP));
    chk("sg_err", 16'(err_count), 16'(3 * STATS));
    chk("sg_gcb", green_cnt_b, 16'(STATS));
    drive(RY, 4);
    drive(RR, 1);
    chk("sg_after_err", 16'(err_count), 16'(3 * STATS));
    chk("sg_fault", 16'(fault), 16'd1);

    // Reset with fault latched; yellow in progress at release is untimed
    pulse_reset("rst5", YR);
    drive(YR, 3);
    chk("rel_ph_a", 16'(phase_a), 16'(PH_YELLOW));
    drive(RR, 1);
    chk("rel_ph_a_red", 16'(phase_a), 16'(PH_RED));
    chk("rel_fault", 16'(fault), 16'd0);
    chk("rel_code", 16'(fault_code), 16'd0);
    chk("rel_err", 16'(err_count), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
